// File: rtl/riscv_fetch_pkg.sv
// Shared constants and helpers for the instruction prefetch unit.
package riscv_fetch_pkg;

  // Bubble presented to decode when nothing is buffered (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned DEFAULT_DEPTH = 4;

  // Counter width able to hold the value DEPTH itself.
  function automatic int unsigned cntWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Fetch-side bus: memory request/response channel, EX redirect and IF outputs.
interface instr_prefetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        StallF;
  logic        fetch_valid;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;

  // Prefetch unit side.
  modport master (
    output req_valid, req_addr, fetch_valid, InstrF, PCF, PCPlus4F,
    input  req_ready, rsp_valid, rsp_data, redirect, redirect_pc, StallF
  );

  // Memory and pipeline side.
  modport slave (
    input  req_valid, req_addr, fetch_valid, InstrF, PCF, PCPlus4F,
    output req_ready, rsp_valid, rsp_data, redirect, redirect_pc, StallF
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous clear; the caller never overfills or over-pops it.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  input  logic                       clear,
  output logic [cntWidth(DEPTH)-1:0] count,
  output logic [WIDTH-1:0]           headData
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cntWidth(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW-1:0]  rdPtr;

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wrPtr] <= pushData;
  end

  // Pointer and occupancy bookkeeping; clear discards everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PtrW'(1);
      if (pop)  rdPtr <= rdPtr + PtrW'(1);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  assign headData = mem[rdPtr];
endmodule

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher with credit-limited issue and redirect flush.
module instr_prefetch
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  instr_prefetch_if.master fetchBus
);
  localparam int unsigned CntW = cntWidth(DEPTH);

  logic [31:0]     fpc;
  logic [31:0]     outPc;
  logic [CntW-1:0] outstanding;
  logic [CntW-1:0] dropCnt;
  logic [CntW-1:0] count;
  logic [31:0]     headData;
  logic [CntW:0]   inFlight;
  logic            reqValid, fire, rspAccept, push, pop, fetchValid;

  // Credits cover both un-answered requests and buffered words, so pushes never overflow.
  always_comb begin
    inFlight   = {1'b0, outstanding} + {1'b0, count};
    reqValid   = !reset && !fetchBus.redirect && (inFlight < (CntW+1)'(DEPTH));
    fire       = reqValid && fetchBus.req_ready;
    rspAccept  = fetchBus.rsp_valid && (outstanding != '0);
    fetchValid = (count != '0);
    push       = rspAccept && (dropCnt == '0) && !fetchBus.redirect;
    pop        = fetchValid && !fetchBus.StallF && !fetchBus.redirect;
  end

  // PC, credit and drop counters; redirect overrides normal advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc         <= RESET_PC;
      outPc       <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      outstanding <= outstanding + CntW'(fire) - CntW'(rspAccept);
      if (fetchBus.redirect) begin
        fpc     <= fetchBus.redirect_pc;
        outPc   <= fetchBus.redirect_pc;
        // Everything still in flight belongs to the old path.
        dropCnt <= outstanding - CntW'(rspAccept);
      end else begin
        if (fire) fpc <= fpc + 32'd4;
        if (pop)  outPc <= outPc + 32'd4;
        if (rspAccept && (dropCnt != '0)) dropCnt <= dropCnt - CntW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushData (fetchBus.rsp_data),
    .pop      (pop),
    .clear    (fetchBus.redirect),
    .count    (count),
    .headData (headData)
  );

  // Output mux: bubble when nothing is buffered.
  always_comb begin
    fetchBus.req_valid   = reqValid;
    fetchBus.req_addr    = fpc;
    fetchBus.fetch_valid = fetchValid;
    fetchBus.InstrF      = fetchValid ? headData : NOP_INSTR;
    fetchBus.PCF         = outPc;
    fetchBus.PCPlus4F    = outPc + 32'd4;
  end

  rspWithoutRequest: assert property (@(posedge clk) disable iff (reset)
    fetchBus.rsp_valid |-> (outstanding != '0));

  reqHeldUntilAccepted: assert property (@(posedge clk) disable iff (reset)
    (fetchBus.req_valid && !fetchBus.req_ready) |=>
      (fetchBus.redirect || (fetchBus.req_valid && $stable(fetchBus.req_addr))));
endmodule
